// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared condition codes, flag indices and fetch state encoding
package cpu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - CR16 condition code evaluation against the ALU flags
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       pass
);

    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_HI:   pass = l;
            CC_LS:   pass = !l;
            CC_GT:   pass = n;
            CC_LE:   pass = !n;
            CC_FS:   pass = f;
            CC_FC:   pass = !f;
            CC_LO:   pass = !l && !z;
            CC_HS:   pass = l || z;
            CC_LT:   pass = !n && !z;
            CC_GE:   pass = n || z;
            CC_UC:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with held instruction and redirects
// Conditional redirects are enabled by defining BRANCH_COND_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rd_data,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic [3:0]        cond,
    input  logic [4:0]        flags,
    output logic              taken
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic              redirect_eff;
    logic              capture;
    logic              consume;

`ifdef BRANCH_COND_EN
    logic cond_pass;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    assign redirect_eff = redirect && cond_pass;
`else
    logic unused_cond;

    assign unused_cond  = ^{cond, flags};
    assign redirect_eff = redirect;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // A taken redirect restarts fetch from any state, dropping any in-flight read.
    always_comb begin
        state_d = state_q;
        if (redirect_eff) begin
            state_d = ST_ISSUE;
        end else begin
            case (state_q)
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  state_d = ST_HOLD;
                ST_HOLD:  state_d = instr_ready ? ST_ISSUE : ST_HOLD;
                default:  state_d = ST_ISSUE;
            endcase
        end
    end

    always_comb begin
        mem_addr = fetch_pc;
        capture  = (state_q == ST_WAIT) && !redirect_eff;
        consume  = (state_q == ST_HOLD) && instr_ready && !redirect_eff;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            taken       <= 1'b0;
        end else begin
            taken <= redirect_eff;
            if (redirect_eff) begin
                fetch_pc    <= redirect_target;
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr       <= mem_rd_data;
                pc          <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                instr_valid <= 1'b1;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
